// File: rtl/phys_free_list_if.sv
// ---------------------------------------------------------------------------
// phys_free_list_if
//   Handshake bundle between rename/commit and the physical-register free list.
//   master : rename + commit side (drives alloc_req / rel_valid / rel_preg)
//   slave  : free list (drives alloc_ready, alloc_preg, free_count, err flags)
//   Signals:
//     alloc_req    rename wants one tag this cycle
//     alloc_ready  list non-empty, alloc_preg valid
//     alloc_preg   tag at head of list
//     rel_valid    commit returns one tag this cycle
//     rel_preg     tag being returned
//     free_count   entries currently in list
//     err_ovf      sticky overflow (release while full)
//     err_dfree    sticky double-free
// ---------------------------------------------------------------------------
interface phys_free_list_if #(
    parameter int PREG_W = 6
);
    logic              alloc_req;
    logic              alloc_ready;
    logic [PREG_W-1:0] alloc_preg;
    logic              rel_valid;
    logic [PREG_W-1:0] rel_preg;
    logic [6:0]        free_count;
    logic              err_ovf;
    logic              err_dfree;

    modport master (
        output alloc_req, rel_valid, rel_preg,
        input  alloc_ready, alloc_preg, free_count, err_ovf, err_dfree
    );

    modport slave (
        input  alloc_req, rel_valid, rel_preg,
        output alloc_ready, alloc_preg, free_count, err_ovf, err_dfree
    );
endinterface

// File: rtl/phys_free_list.sv
// ---------------------------------------------------------------------------
// phys_free_list
//   Circular FIFO of free physical-register tags. Rename pops the head tag
//   (presented combinationally, taken at the edge); commit pushes back the
//   superseded tag of each retiring instruction. Occupancy is tracked in a
//   registered count from which full/empty are derived.
//   Ports:
//     clk   in  clock, rising edge
//     rstn  in  asynchronous reset, active low
//     fl    slave modport of phys_free_list_if (alloc/release handshake,
//           free_count, sticky err_ovf / err_dfree)
//   Build option:
//     FREELIST_DOUBLE_FREE_CHECK_EN  adds an in_list bitmap that rejects a
//     release of a tag already on the list and flags err_dfree. Without it
//     err_dfree is tied low and duplicates are enqueued.
// ---------------------------------------------------------------------------
module phys_free_list #(
    parameter int PREG_W   = 6,
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32
) (
    input logic             clk,
    input logic             rstn,
    phys_free_list_if.slave fl
);
    localparam int         FL_DEPTH = NUM_PREG - NUM_AREG;
    localparam int         PTR_W    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam logic [6:0] DEPTH_C  = 7'(FL_DEPTH);

    logic [PREG_W-1:0] mem_q [FL_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [6:0]        count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full, rel_try, dup, alloc_acc, rel_acc;

    // Explicit wrap so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FL_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake decode: everything is judged against the pre-edge count, so a
    // release while empty is not visible to alloc until the next cycle.
    always_comb begin
        full      = (count_q == DEPTH_C);
        rel_try   = fl.rel_valid && (fl.rel_preg != '0);
        alloc_acc = fl.alloc_req && (count_q != 7'd0);
        rel_acc   = rel_try && !full && !dup;
    end

    always_comb begin
        head_d  = alloc_acc ? ptr_inc(head_q) : head_q;
        tail_d  = rel_acc   ? ptr_inc(tail_q) : tail_q;
        count_d = count_q + {6'd0, rel_acc} - {6'd0, alloc_acc};
        ovf_d   = ovf_q | (rel_try && full);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= DEPTH_C;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Reset image: the list holds every tag not mapped architecturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FL_DEPTH; i++) mem_q[i] <= PREG_W'(NUM_AREG + i);
        end else if (rel_acc) begin
            mem_q[tail_q] <= fl.rel_preg;
        end
    end

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    logic [NUM_PREG-1:0] in_list_q, in_list_d;
    logic                dfree_q, dfree_d;

    // A tag is "in list" from accepted release until it is allocated again.
    always_comb begin
        dup       = in_list_q[fl.rel_preg];
        dfree_d   = dfree_q | (rel_try && dup);
        in_list_d = in_list_q;
        if (alloc_acc) in_list_d[fl.alloc_preg] = 1'b0;
        if (rel_acc)   in_list_d[fl.rel_preg]   = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_PREG; i++) in_list_q[i] <= (i >= NUM_AREG);
            dfree_q <= 1'b0;
        end else begin
            in_list_q <= in_list_d;
            dfree_q   <= dfree_d;
        end
    end

    assign fl.err_dfree = dfree_q;
`else
    assign dup          = 1'b0;
    assign fl.err_dfree = 1'b0;
`endif

    assign fl.alloc_ready = (count_q != 7'd0);
    assign fl.alloc_preg  = mem_q[head_q];
    assign fl.free_count  = count_q;
    assign fl.err_ovf     = ovf_q;
endmodule

// File: tb/tb_phys_free_list.sv
// ---------------------------------------------------------------------------
// tb_phys_free_list
//   Directed scenarios plus a randomized run checked against a queue-based
//   model of the free list. Works with or without
//   FREELIST_DOUBLE_FREE_CHECK_EN defined.
// ---------------------------------------------------------------------------
module tb_phys_free_list;
    logic clk  = 1'b0;
    logic rstn = 1'b0;

    phys_free_list_if #(.PREG_W(6)) fl ();

    phys_free_list #(.PREG_W(6), .NUM_PREG(64), .NUM_AREG(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .fl   (fl)
    );

    always #5 clk = ~clk;

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    localparam bit DF_EN = 1'b1;
`else
    localparam bit DF_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO of free tags, membership set, sticky flags.
    int q[$];
    bit inlist[64];
    bit m_ovf, m_dfree;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(32 + i);
        for (int i = 0; i < 64; i++) inlist[i] = (i >= 32);
        m_ovf   = 1'b0;
        m_dfree = 1'b0;
    endtask

    task automatic model_step(input bit req, input bit rv, input int rp);
        bit a, dup, racc;
        int tag;
        a    = req && (q.size() != 0);
        dup  = DF_EN && inlist[rp];
        racc = rv && (rp != 0) && (q.size() < 32) && !dup;
        if (rv && rp != 0 && q.size() == 32) m_ovf = 1'b1;
        if (rv && rp != 0 && dup) m_dfree = 1'b1;
        if (a) begin
            tag = q.pop_front();
            inlist[tag] = 1'b0;
        end
        if (racc) begin
            q.push_back(rp);
            inlist[rp] = 1'b1;
        end
    endtask

    // Apply inputs for one cycle, advance model at the edge, land 1 after it.
    task automatic cycle(input bit req, input bit rv, input int rp);
        fl.alloc_req = req;
        fl.rel_valid = rv;
        fl.rel_preg  = 6'(rp);
        @(posedge clk);
        model_step(req, rv, rp);
        #1;
    endtask

    task automatic do_reset();
        fl.alloc_req = 1'b0;
        fl.rel_valid = 1'b0;
        fl.rel_preg  = '0;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (fl.free_count !== 7'd32) begin n_fail++; $display("FAIL reset_count got %0d exp 32", fl.free_count); end
        n_tests++; if (fl.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b exp 1", fl.alloc_ready); end
        n_tests++; if (fl.alloc_preg !== 6'd32) begin n_fail++; $display("FAIL reset_preg got %0d exp 32", fl.alloc_preg); end
        n_tests++; if (fl.err_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b exp 0", fl.err_ovf); end
        n_tests++; if (fl.err_dfree !== 1'b0) begin n_fail++; $display("FAIL reset_dfree got %0b exp 0", fl.err_dfree); end
    endtask

    task automatic test_alloc_basic();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (fl.alloc_preg !== 6'(32 + i)) begin n_fail++; $display("FAIL alloc_seq[%0d] got %0d exp %0d", i, fl.alloc_preg, 32 + i); end
            cycle(1, 0, 0);
        end
        fl.alloc_req = 1'b0;
        n_tests++; if (fl.free_count !== 7'd29) begin n_fail++; $display("FAIL alloc3_count got %0d exp 29", fl.free_count); end
        n_tests++; if (fl.alloc_preg !== 6'd35) begin n_fail++; $display("FAIL alloc3_preg got %0d exp 35", fl.alloc_preg); end
    endtask

    // Drain, then release-while-empty, then simultaneous alloc+release at count 1.
    task automatic test_drain_and_simul();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            n_tests++; if (fl.alloc_preg !== 6'(32 + i)) begin n_fail++; $display("FAIL drain_seq[%0d] got %0d exp %0d", i, fl.alloc_preg, 32 + i); end
            cycle(1, 0, 0);
        end
        n_tests++; if (fl.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL drain_ready got %0b exp 0", fl.alloc_ready); end
        n_tests++; if (fl.free_count !== 7'd0) begin n_fail++; $display("FAIL drain_count got %0d exp 0", fl.free_count); end
        // release 5 with alloc_req in the same cycle: no grant from an empty list
        fl.alloc_req = 1'b1; fl.rel_valid = 1'b1; fl.rel_preg = 6'd5;
        #1;
        n_tests++; if (fl.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL nobypass_ready got %0b exp 0", fl.alloc_ready); end
        @(posedge clk); model_step(1, 1, 5); #1;
        n_tests++; if (fl.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL refill_ready got %0b exp 1", fl.alloc_ready); end
        n_tests++; if (fl.alloc_preg !== 6'd5) begin n_fail++; $display("FAIL refill_preg got %0d exp 5", fl.alloc_preg); end
        n_tests++; if (fl.free_count !== 7'd1) begin n_fail++; $display("FAIL refill_count got %0d exp 1", fl.free_count); end
        cycle(1, 1, 40);
        n_tests++; if (fl.free_count !== 7'd1) begin n_fail++; $display("FAIL simul_count got %0d exp 1", fl.free_count); end
        n_tests++; if (fl.alloc_preg !== 6'd40) begin n_fail++; $display("FAIL simul_preg got %0d exp 40", fl.alloc_preg); end
        cycle(0, 1, 0);
        n_tests++; if (fl.free_count !== 7'd1) begin n_fail++; $display("FAIL x0_count got %0d exp 1", fl.free_count); end
        n_tests++; if (fl.err_ovf !== 1'b0 || fl.err_dfree !== 1'b0) begin n_fail++; $display("FAIL x0_errs got %0b%0b exp 00", fl.err_ovf, fl.err_dfree); end
    endtask

    task automatic test_overflow();
        do_reset();
        cycle(0, 1, 7);
        fl.rel_valid = 1'b0;
        n_tests++; if (fl.err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0b exp 1", fl.err_ovf); end
        n_tests++; if (fl.free_count !== 7'd32) begin n_fail++; $display("FAIL ovf_count got %0d exp 32", fl.free_count); end
        n_tests++; if (fl.alloc_preg !== 6'd32) begin n_fail++; $display("FAIL ovf_preg got %0d exp 32", fl.alloc_preg); end
        repeat (5) cycle(0, 0, 0);
        n_tests++; if (fl.err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b exp 1", fl.err_ovf); end
        do_reset();
        n_tests++; if (fl.err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0b exp 0", fl.err_ovf); end
        // full + alloc + release: release judged against full pre-edge count
        cycle(1, 1, 50);
        n_tests++; if (fl.free_count !== 7'd31) begin n_fail++; $display("FAIL fullboth_count got %0d exp 31", fl.free_count); end
        n_tests++; if (fl.err_ovf !== 1'b1) begin n_fail++; $display("FAIL fullboth_ovf got %0b exp 1", fl.err_ovf); end
        n_tests++; if (fl.alloc_preg !== 6'd33) begin n_fail++; $display("FAIL fullboth_preg got %0d exp 33", fl.alloc_preg); end
        n_tests++; if (fl.err_dfree !== m_dfree) begin n_fail++; $display("FAIL fullboth_dfree got %0b exp %0b", fl.err_dfree, m_dfree); end
    endtask

    task automatic test_double_free_and_reset();
        do_reset();
        repeat (32) cycle(1, 0, 0);
        for (int i = 0; i < 32; i++) cycle(0, 1, 32 + i);
        n_tests++; if (fl.free_count !== 7'd32) begin n_fail++; $display("FAIL refull_count got %0d exp 32", fl.free_count); end
        n_tests++; if (fl.err_ovf !== 1'b0 || fl.err_dfree !== 1'b0) begin n_fail++; $display("FAIL refull_errs got %0b%0b exp 00", fl.err_ovf, fl.err_dfree); end
        cycle(0, 1, 32);
        n_tests++; if (fl.free_count !== 7'd32) begin n_fail++; $display("FAIL dfree_count got %0d exp 32", fl.free_count); end
        n_tests++; if (fl.err_dfree !== DF_EN) begin n_fail++; $display("FAIL dfree_flag got %0b exp %0b", fl.err_dfree, DF_EN); end
        // mid-burst async reset
        cycle(1, 0, 0);
        cycle(1, 1, 32);
        cycle(1, 0, 0);
        rstn = 1'b0;
        #1;
        n_tests++; if (fl.free_count !== 7'd32) begin n_fail++; $display("FAIL midrst_count got %0d exp 32", fl.free_count); end
        n_tests++; if (fl.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %0b exp 1", fl.alloc_ready); end
        n_tests++; if (fl.alloc_preg !== 6'd32) begin n_fail++; $display("FAIL midrst_preg got %0d exp 32", fl.alloc_preg); end
        n_tests++; if (fl.err_ovf !== 1'b0 || fl.err_dfree !== 1'b0) begin n_fail++; $display("FAIL midrst_errs got %0b%0b exp 00", fl.err_ovf, fl.err_dfree); end
        do_reset();
    endtask

    task automatic test_random();
        int outq[$];
        bit req, rv;
        int rp, k;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req = ($urandom_range(0, 99) < 50);
            rv  = ($urandom_range(0, 99) < 50);
            if (rv && outq.size() != 0 && $urandom_range(0, 99) < 75) begin
                k  = $urandom_range(0, outq.size() - 1);
                rp = outq[k];
                outq.delete(k);
            end else begin
                rp = $urandom_range(0, 63);
            end
            if (req && q.size() != 0) outq.push_back(q[0]);
            cycle(req, rv, rp);
            n_tests++; if (fl.free_count !== 7'(q.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, fl.free_count, q.size()); end
            n_tests++; if (fl.alloc_ready !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_ready c=%0d got %0b exp %0b", c, fl.alloc_ready, q.size() != 0); end
            if (q.size() != 0) begin
                n_tests++; if (fl.alloc_preg !== 6'(q[0])) begin n_fail++; $display("FAIL rnd_preg c=%0d got %0d exp %0d", c, fl.alloc_preg, q[0]); end
            end
            n_tests++; if (fl.err_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c=%0d got %0b exp %0b", c, fl.err_ovf, m_ovf); end
            n_tests++; if (fl.err_dfree !== m_dfree) begin n_fail++; $display("FAIL rnd_dfree c=%0d got %0b exp %0b", c, fl.err_dfree, m_dfree); end
        end
    endtask

    initial begin
        fl.alloc_req = 1'b0;
        fl.rel_valid = 1'b0;
        fl.rel_preg  = '0;
        model_reset();
        test_reset();
        test_alloc_basic();
        test_drain_and_simul();
        test_overflow();
        test_double_free_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
